// File: rtl/i2c_slave_reg_ctrl_if.sv
// Byte-stream handshake bundle between i2c_slave and the register sequencer.
// master = i2c_slave side, slave = register sequencer side.
interface i2c_slave_reg_ctrl_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// Pointer-protocol register sequencer for i2c_slave.
// Prefetches read data so the bus side never stalls on a register read.
module i2c_slave_reg_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_slave_reg_ctrl_if.slave   ax,
  input  logic                  bus_addressed,
  input  logic                  bus_active,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [7:0]            reg_rd_data,
  output logic [ADDR_WIDTH-1:0] pointer
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_WR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] INC =
    ADDR_WIDTH'(AUTO_INC != 0);

  state_t     state;
  logic       addr_q;
  logic       addr_d;
  logic       act_q;
  logic       first_byte;
  logic       rd_vld;
  logic       tready_q;
  logic       tvalid_q;
  logic [7:0] tdata_q;
  logic       unused_tlast;

  assign unused_tlast     = ax.s_axis_tlast;
  assign ax.s_axis_tready = tready_q;
  assign ax.m_axis_tvalid = tvalid_q;
  assign ax.m_axis_tdata  = tdata_q;
  assign ax.m_axis_tlast  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= 1'b0;
      addr_d      <= 1'b0;
      act_q       <= 1'b0;
      first_byte  <= 1'b0;
      rd_vld      <= 1'b0;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      pointer     <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
    end else begin
      addr_q    <= bus_addressed;
      addr_d    <= addr_q;
      act_q     <= bus_active;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_vld    <= reg_rd_en;
      // Losing the bus drops any prefetched byte; an issued write still counts.
      if (state != S_IDLE && !act_q) begin
        state    <= S_IDLE;
        tready_q <= 1'b0;
        tvalid_q <= 1'b0;
        if (state == S_WR)
          pointer <= pointer + INC;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (act_q)
              state <= S_FETCH;
          end
          S_FETCH: begin
            reg_addr  <= pointer;
            reg_rd_en <= 1'b1;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if (rd_vld) begin
              tdata_q  <= reg_rd_data;
              tvalid_q <= 1'b1;
              tready_q <= 1'b1;
              state    <= S_VALID;
            end
          end
          S_VALID: begin
            if (ax.s_axis_tvalid) begin
              tready_q   <= 1'b0;
              tvalid_q   <= 1'b0;
              first_byte <= 1'b0;
              if (first_byte) begin
                pointer <= ax.s_axis_tdata[ADDR_WIDTH-1:0];
                state   <= S_FETCH;
              end else begin
                reg_wr_data <= ax.s_axis_tdata;
                reg_addr    <= pointer;
                reg_wr_en   <= 1'b1;
                state       <= S_WR;
              end
            end else if (ax.m_axis_tready) begin
              tready_q   <= 1'b0;
              tvalid_q   <= 1'b0;
              first_byte <= 1'b0;
              pointer    <= pointer + INC;
              state      <= S_FETCH;
            end
          end
          S_WR: begin
            pointer <= pointer + INC;
            state   <= S_FETCH;
          end
          default: state <= S_IDLE;
        endcase
      end
      if (addr_q && !addr_d)
        first_byte <= 1'b1;
    end
  end

endmodule
